// File: rtl/wrap_out_fifo.sv
// wrap_out_fifo: circular result buffer between a multiplier producer and a
// consumer. Registered occupancy, no bypass at empty, sticky overflow on drop.
module wrap_out_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             doneMul,
   input  logic [WIDTH-1:0] in,
   input  logic             resultaccept,
   output logic             resultready,
   output logic [WIDTH-1:0] Final,
   output logic             full,
   output logic [CW-1:0]    count,
   output logic             overflow
);

   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             overflow_q, overflow_d;
   logic             push, pop;
   logic             is_full, is_empty;

   assign is_full  = (count_q == CW'(DEPTH));
   assign is_empty = (count_q == '0);

   // Handshake decode and next-state for pointers, count and overflow flag.
   // A pop frees a slot in the same cycle, so a push is still accepted when full.
   always_comb begin
      pop        = !is_empty && resultaccept;
      push       = doneMul && (!is_full || pop);
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !pop) count_d = count_q + CW'(1);
      if (pop && !push) count_d = count_q - CW'(1);
      if (doneMul && !push) overflow_d = 1'b1;
   end

   // Control state registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage write; contents are not cleared by reset, only gated by push.
   always_ff @(posedge clk) begin
      if (rst && push) mem_q[wr_ptr_q] <= in;
   end

   // Outputs derive from registered state only; Final is masked to zero when empty.
   always_comb begin
      resultready = !is_empty;
      full        = is_full;
      count       = count_q;
      overflow    = overflow_q;
      Final       = is_empty ? '0 : mem_q[rd_ptr_q];
   end

endmodule

// File: tb/tb_wrap_out_fifo.sv
// Testbench for wrap_out_fifo: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_wrap_out_fifo;

   localparam int W  = 32;
   localparam int D  = 4;
   localparam int CW = $clog2(D + 1);

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          doneMul = 1'b0;
   logic [W-1:0]  in_d = '0;
   logic          resultaccept = 1'b0;
   logic          resultready;
   logic [W-1:0]  Final;
   logic          full;
   logic [CW-1:0] count;
   logic          overflow;

   int tests = 0;
   int fails = 0;

   logic [W-1:0] mq[$];
   bit           m_ovf = 1'b0;

   wrap_out_fifo #(.WIDTH(W), .DEPTH(D)) dut (
      .clk(clk), .rst(rst), .doneMul(doneMul), .in(in_d),
      .resultaccept(resultaccept), .resultready(resultready), .Final(Final),
      .full(full), .count(count), .overflow(overflow)
   );

   always #5 clk = ~clk;

   // Apply one cycle of inputs, advance the model by the FIFO rules, then
   // step past the rising edge so outputs can be sampled.
   task automatic drive(input logic dm, input logic [W-1:0] d, input logic acc, input logic r);
      bit p_pop, p_push;
      doneMul = dm; in_d = d; resultaccept = acc; rst = r;
      if (!r) begin
         mq.delete();
         m_ovf = 1'b0;
      end else begin
         p_pop  = (mq.size() != 0) && acc;
         p_push = dm && ((mq.size() < D) || p_pop);
         if (dm && !p_push) m_ovf = 1'b1;
         if (p_pop) void'(mq.pop_front());
         if (p_push) mq.push_back(d);
      end
      @(posedge clk); #1;
      doneMul = 1'b0; resultaccept = 1'b0; rst = 1'b1;
   endtask

   task automatic test_reset();
      drive(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'h1234_0000 + 32'(i), 1'b1, 1'b0);
         tests++;
         if (count !== '0 || resultready !== 1'b0 || full !== 1'b0 ||
             overflow !== 1'b0 || Final !== '0) begin
            fails++;
            $display("FAIL reset_hold: count=%0d ready=%b full=%b ovf=%b Final=%h, required 0/0/0/0/0",
                     count, resultready, full, overflow, Final);
         end
      end
   endtask

   task automatic test_single();
      drive(1'b0, '0, 1'b0, 1'b0);
      doneMul = 1'b1; in_d = 32'h0000_00A5; #1;
      tests++;
      if (Final !== '0 || resultready !== 1'b0) begin
         fails++;
         $display("FAIL single_no_bypass: Final=%h ready=%b, required 0/0", Final, resultready);
      end
      drive(1'b1, 32'h0000_00A5, 1'b0, 1'b1);
      tests++;
      if (resultready !== 1'b1 || Final !== 32'h0000_00A5 || count !== CW'(1)) begin
         fails++;
         $display("FAIL single_push: ready=%b Final=%h count=%0d, required 1/000000a5/1",
                  resultready, Final, count);
      end
      drive(1'b0, '0, 1'b1, 1'b1);
      tests++;
      if (resultready !== 1'b0 || Final !== '0 || count !== '0) begin
         fails++;
         $display("FAIL single_pop: ready=%b Final=%h count=%0d, required 0/0/0",
                  resultready, Final, count);
      end
   endtask

   task automatic test_fill_drain();
      drive(1'b0, '0, 1'b0, 1'b0);
      for (int i = 1; i <= 4; i++) drive(1'b1, 32'(i), 1'b0, 1'b1);
      tests++;
      if (full !== 1'b1 || count !== CW'(4)) begin
         fails++;
         $display("FAIL fill_full: full=%b count=%0d, required 1/4", full, count);
      end
      for (int i = 1; i <= 4; i++) begin
         tests++;
         if (Final !== 32'(i)) begin
            fails++;
            $display("FAIL fill_drain_order: Final=%0d, required %0d", Final, i);
         end
         drive(1'b0, '0, 1'b1, 1'b1);
      end
      tests++;
      if (resultready !== 1'b0 || count !== '0 || Final !== '0 || full !== 1'b0) begin
         fails++;
         $display("FAIL fill_drain_empty: ready=%b count=%0d Final=%h full=%b, required 0/0/0/0",
                  resultready, count, Final, full);
      end
   endtask

   task automatic test_overflow();
      drive(1'b0, '0, 1'b0, 1'b0);
      for (int i = 1; i <= 4; i++) drive(1'b1, 32'(i), 1'b0, 1'b1);
      drive(1'b1, 32'd5, 1'b0, 1'b1);
      tests++;
      if (overflow !== 1'b1 || count !== CW'(4)) begin
         fails++;
         $display("FAIL ovf_set: overflow=%b count=%0d, required 1/4", overflow, count);
      end
      for (int i = 1; i <= 4; i++) begin
         tests++;
         if (Final !== 32'(i)) begin
            fails++;
            $display("FAIL ovf_drain_order: Final=%0d, required %0d", Final, i);
         end
         drive(1'b0, '0, 1'b1, 1'b1);
      end
      drive(1'b0, '0, 1'b0, 1'b1);
      tests++;
      if (overflow !== 1'b1 || count !== '0) begin
         fails++;
         $display("FAIL ovf_sticky: overflow=%b count=%0d, required 1/0", overflow, count);
      end
      drive(1'b0, '0, 1'b0, 1'b0);
      tests++;
      if (overflow !== 1'b0) begin
         fails++;
         $display("FAIL ovf_clear: overflow=%b, required 0", overflow);
      end
   endtask

   task automatic test_full_push_pop();
      drive(1'b0, '0, 1'b0, 1'b0);
      for (int i = 1; i <= 4; i++) drive(1'b1, 32'(i), 1'b0, 1'b1);
      drive(1'b1, 32'd5, 1'b1, 1'b1);
      tests++;
      if (count !== CW'(4) || overflow !== 1'b0 || full !== 1'b1) begin
         fails++;
         $display("FAIL fullpp_count: count=%0d ovf=%b full=%b, required 4/0/1", count, overflow, full);
      end
      for (int i = 2; i <= 5; i++) begin
         tests++;
         if (Final !== 32'(i)) begin
            fails++;
            $display("FAIL fullpp_order: Final=%0d, required %0d", Final, i);
         end
         drive(1'b0, '0, 1'b1, 1'b1);
      end
      tests++;
      if (resultready !== 1'b0) begin
         fails++;
         $display("FAIL fullpp_empty: ready=%b, required 0", resultready);
      end
   endtask

   task automatic test_wrap_stream();
      drive(1'b0, '0, 1'b0, 1'b0);
      for (int i = 1; i <= 20; i++) begin
         drive(1'b1, 32'(i), 1'b1, 1'b1);
         tests++;
         if (Final !== 32'(i) || count !== CW'(1) || overflow !== 1'b0) begin
            fails++;
            $display("FAIL wrap_stream: step %0d Final=%0d count=%0d ovf=%b, required %0d/1/0",
                     i, Final, count, overflow, i);
         end
      end
      drive(1'b0, '0, 1'b1, 1'b1);
      tests++;
      if (count !== '0 || resultready !== 1'b0) begin
         fails++;
         $display("FAIL wrap_stream_end: count=%0d ready=%b, required 0/0", count, resultready);
      end
   endtask

   task automatic test_reset_mid();
      drive(1'b0, '0, 1'b0, 1'b0);
      for (int i = 1; i <= 3; i++) drive(1'b1, 32'(10 + i), 1'b0, 1'b1);
      drive(1'b1, 32'd99, 1'b1, 1'b0);
      tests++;
      if (count !== '0 || resultready !== 1'b0 || Final !== '0 || overflow !== 1'b0 || full !== 1'b0) begin
         fails++;
         $display("FAIL reset_mid: count=%0d ready=%b Final=%h ovf=%b full=%b, required 0/0/0/0/0",
                  count, resultready, Final, overflow, full);
      end
      drive(1'b1, 32'h0000_00A5, 1'b0, 1'b1);
      tests++;
      if (resultready !== 1'b1 || Final !== 32'h0000_00A5 || count !== CW'(1)) begin
         fails++;
         $display("FAIL reset_mid_push: ready=%b Final=%h count=%0d, required 1/000000a5/1",
                  resultready, Final, count);
      end
   endtask

   task automatic test_random();
      logic [W-1:0] exp_final;
      drive(1'b0, '0, 1'b0, 1'b0);
      for (int i = 0; i < 400; i++) begin
         drive(($urandom_range(0, 99) < 60), $urandom, ($urandom_range(0, 99) < 45),
               ($urandom_range(0, 63) != 0));
         exp_final = (mq.size() != 0) ? mq[0] : '0;
         tests++;
         if (count !== CW'(mq.size()) || resultready !== (mq.size() != 0) ||
             full !== (mq.size() == D) || overflow !== m_ovf || Final !== exp_final) begin
            fails++;
            $display("FAIL random: cyc %0d count=%0d ready=%b full=%b ovf=%b Final=%h, required %0d/%b/%b/%b/%h",
                     i, count, resultready, full, overflow, Final, mq.size(),
                     (mq.size() != 0), (mq.size() == D), m_ovf, exp_final);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_fill_drain();
      test_overflow();
      test_full_push_pop();
      test_wrap_stream();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/wrap_out_fifo.md
WRAP_OUT_FIFO -- requirements
Module: wrap_out_fifo

Interface
REQ-001 Parameter WIDTH, default 32, result data width in bits (legal 1..64).
REQ-002 Parameter DEPTH, default 4, number of buffered results; power of two, legal 2..16.
REQ-003 Parameter CW, default $clog2(DEPTH+1), width of the occupancy count.
REQ-004 Port clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port rst  input  1  reset, synchronous, active-low (state cleared on rising clk edge while rst==0).
REQ-006 Port doneMul  input  1  producer strobe: in[] holds a valid result this cycle.
REQ-007 Port in  input  WIDTH  result data from producer.
REQ-008 Port resultaccept  input  1  consumer takes the head result this cycle.
REQ-009 Port resultready  output  1  head result valid on Final.
REQ-010 Port Final  output  WIDTH  head result; zero when empty.
REQ-011 Port full  output  1  buffer holds DEPTH entries.
REQ-012 Port count  output  CW  current occupancy, 0..DEPTH.
REQ-013 Port overflow  output  1  sticky: a result was dropped.

Function
REQ-014 Storage SHALL be a circular buffer of DEPTH entries with write pointer, read pointer (each $clog2(DEPTH) bits, wrapping DEPTH-1 -> 0) and registered count.
REQ-015 Push SHALL occur when doneMul==1 and (count<DEPTH or pop occurs in the same cycle); in is written at write pointer, pointer advances.
REQ-016 Pop SHALL occur when resultready==1 and resultaccept==1; read pointer advances.
REQ-017 resultaccept while resultready==0 SHALL be ignored (no pointer/count change).
REQ-018 Simultaneous push and pop SHALL leave count unchanged; allowed at count==DEPTH (full) and count==0 does not apply since pop requires resultready.
REQ-019 At count==0 a push SHALL NOT bypass: the pushed value appears on Final and resultready rises the cycle after the push edge (latency 1 clock).
REQ-020 count SHALL update as count+push-pop on each edge; full==(count==DEPTH); resultready==(count!=0); all three registered or derived from registered count only.
REQ-021 Final SHALL equal the entry at read pointer when count!=0 and all-zero when count==0; no combinational path from in or doneMul to Final.
REQ-022 doneMul with count==DEPTH and no pop SHALL drop in, leave buffer/pointers unchanged, and set overflow=1.
REQ-023 overflow SHALL remain 1 until reset; it does not affect push/pop behaviour.
REQ-024 Ordering SHALL be strict FIFO across pointer wrap-around; no entry reordered or duplicated.
REQ-025 Implementation SHALL support back-to-back push every cycle and pop every cycle with sustained throughput of one result per clock when not full.

Reset
REQ-026 With rst==0 at a rising edge: pointers=0, count=0, resultready=0, full=0, overflow=0, Final=0; storage contents need not be cleared.
REQ-027 Reset SHALL take priority over simultaneous doneMul/resultaccept; in-flight results are discarded.
REQ-028 Outputs SHALL hold reset values from the first edge after rst falls until the first push after rst returns to 1.

Verification
REQ-029 Single result: reset, doneMul=1 in=32'h0000_00A5 one cycle -> next cycle resultready=1, Final=32'h0000_00A5, count=1; accept one cycle -> next cycle resultready=0, Final=0, count=0.
REQ-030 Fill and drain (DEPTH=4): push 1,2,3,4 on consecutive cycles, no accept -> full=1, count=4; accept 4 cycles -> Final sequence 1,2,3,4, then empty.
REQ-031 Overflow: full with 1..4, doneMul in=5 without accept -> overflow=1, count=4, drain yields 1,2,3,4 only; overflow stays 1 until rst=0.
REQ-032 Full push+pop: full with 1..4, doneMul in=5 and resultaccept same cycle -> count=4, overflow=0, drain yields 2,3,4,5.
REQ-033 Wrap-around streaming: 20 results 1..20 pushed every cycle with accept held high -> Final order 1..20 across multiple pointer wraps, count never exceeds 1, no overflow.
REQ-034 Reset mid-operation: count=3, assert rst=0 for one edge concurrent with doneMul and resultaccept -> count=0, resultready=0, Final=0, overflow=0; next push behaves as REQ-029.
